// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  localparam logic PCTL_TRUE  = 1'b1;
  localparam logic PCTL_FALSE = 1'b0;

  localparam int unsigned PCTL_MULDIV_CYCLES_DEF = 32;

  typedef enum logic {
    PCTL_RUN    = 1'b0,
    PCTL_MULDIV = 1'b1
  } pctl_state_e;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Saturating event counter with enable and synchronous active-low reset.
module pipeline_ctrl_perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect,
// multi-cycle mul/div and memory wait states, plus a stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = PCTL_MULDIV_CYCLES_DEF,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_ex_hazard,
  input  logic             branch_taken,
  input  logic             muldiv_start,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             memwb_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             muldiv_busy,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned CNT_BITS = $clog2(MULDIV_CYCLES);

  pctl_state_e         state_q;
  pctl_state_e         state_d;
  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_d;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pc_stall    = PCTL_FALSE;
    ifid_stall  = PCTL_FALSE;
    idex_stall  = PCTL_FALSE;
    exmem_stall = PCTL_FALSE;
    memwb_stall = PCTL_FALSE;
    ifid_flush  = PCTL_FALSE;
    idex_flush  = PCTL_FALSE;
    exmem_flush = PCTL_FALSE;
    memwb_flush = PCTL_FALSE;
    muldiv_busy = PCTL_FALSE;
    muldiv_done = PCTL_FALSE;

    if (!rst_n) begin
      ifid_flush  = PCTL_TRUE;
      idex_flush  = PCTL_TRUE;
      exmem_flush = PCTL_TRUE;
      memwb_flush = PCTL_TRUE;
      state_d     = PCTL_RUN;
      count_d     = '0;
    end else begin
      case (state_q)
        PCTL_MULDIV: begin
          muldiv_busy = PCTL_TRUE;
          if (count_q != '0) begin
            count_d     = count_q - CNT_BITS'(1);
            pc_stall    = PCTL_TRUE;
            ifid_stall  = PCTL_TRUE;
            idex_stall  = PCTL_TRUE;
            exmem_flush = PCTL_TRUE;
          end else begin
            muldiv_done = PCTL_TRUE;
            // Result cycle: the front end advances, so a pending fetch still stalls PC.
            if (!dmem_wait) begin
              state_d = PCTL_RUN;
              if (imem_wait) begin
                pc_stall   = PCTL_TRUE;
                ifid_flush = PCTL_TRUE;
              end
            end
          end
        end
        default: begin
          if (!dmem_wait) begin
            if (mem_ex_hazard || muldiv_start) begin
              pc_stall    = PCTL_TRUE;
              ifid_stall  = PCTL_TRUE;
              idex_stall  = PCTL_TRUE;
              exmem_flush = PCTL_TRUE;
              if (!mem_ex_hazard) begin
                count_d = CNT_BITS'(MULDIV_CYCLES - 1);
                state_d = PCTL_MULDIV;
              end
            end else if (branch_taken) begin
              ifid_flush = PCTL_TRUE;
              idex_flush = PCTL_TRUE;
            end else if (imem_wait) begin
              pc_stall   = PCTL_TRUE;
              ifid_flush = PCTL_TRUE;
            end
          end
        end
      endcase

      // A MEM-stage wait freezes everything upstream and bubbles MEM/WB.
      if (dmem_wait) begin
        pc_stall    = PCTL_TRUE;
        ifid_stall  = PCTL_TRUE;
        idex_stall  = PCTL_TRUE;
        exmem_stall = PCTL_TRUE;
        ifid_flush  = PCTL_FALSE;
        idex_flush  = PCTL_FALSE;
        exmem_flush = PCTL_FALSE;
        memwb_flush = PCTL_TRUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PCTL_RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  pipeline_ctrl_perf_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (pc_stall && rst_n),
    .count_o (stall_cycles)
  );

endmodule
